// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer, the video timing source and the ball datapath.
// The slave side is the sequencer; the master side drives frames, buttons and ball position.
interface pong_game_ctrl_if;
    logic        frame_start;
    logic        start_btn;
    logic        pause_btn;
    logic [1:0]  speed;
    logic [12:0] ball_col;
    logic [12:0] ball_row;
    logic        ball_step;
    logic        ball_rst_n;
    logic [2:0]  state;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        game_over;
    logic [12:0] dbg_row;

    modport master (
        output frame_start, start_btn, pause_btn, speed, ball_col, ball_row,
        input  ball_step, ball_rst_n, state, score_l, score_r, game_over, dbg_row
    );

    modport slave (
        input  frame_start, start_btn, pause_btn, speed, ball_col, ball_row,
        output ball_step, ball_rst_n, state, score_l, score_r, game_over, dbg_row
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: turns frame strobes into ball step bursts, detects goals,
// keeps score and runs the serve/play/pause/point/over flow.
//
// state | meaning
// IDLE  | waiting for start, ball held in reset
// SERVE | ball held in reset for SERVE_FRAMES frame strobes
// PLAY  | each frame issues a burst of speed+1 steps, goals checked between steps
// PAUSE | ball released but frozen, no steps
// POINT | one cycle to credit the scorer
// OVER  | final score held until a new start
module pong_game_ctrl #(
    parameter logic [3:0]  MAX_SCORE    = 4'd7,
    parameter logic [7:0]  SERVE_FRAMES = 8'd60,
    parameter logic [12:0] LEFT_GOAL    = 13'd6,
    parameter logic [12:0] RIGHT_GOAL   = 13'd610
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_POINT = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        start_q, pause_q;
    logic [7:0]  serve_cnt_q, serve_cnt_d;
    logic        burst_q, burst_d;
    logic        check_q, check_d;
    logic [1:0]  rem_q, rem_d;
    logic        pend_q, pend_d;
    logic        scorer_l_q, scorer_l_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic        step_q, step_d;
    logic        rst_n_q, rst_n_d;
    logic        over_q, over_d;
    logic [12:0] row_q;

    logic        start_edge, pause_edge, pause_now;
    logic        goal_l, goal_r;
    logic [7:0]  serve_inc;
    logic [3:0]  next_l, next_r;

    assign start_edge = bus.start_btn & ~start_q;
    assign pause_edge = bus.pause_btn & ~pause_q;
    assign pause_now  = pend_q | pause_edge;
    // goal_l: the left player scored (ball reached the right wall)
    assign goal_l     = (bus.ball_col >= RIGHT_GOAL);
    assign goal_r     = (bus.ball_col <= LEFT_GOAL);
    assign serve_inc  = serve_cnt_q + 8'd1;
    assign next_l     = score_l_q + 4'd1;
    assign next_r     = score_r_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        burst_d     = burst_q;
        check_d     = step_q;
        rem_d       = rem_q;
        pend_d      = pend_q;
        scorer_l_d  = scorer_l_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        step_d      = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    serve_cnt_d = 8'd0;
                    state_d     = S_SERVE;
                end
            end
            S_SERVE: begin
                if (bus.frame_start) begin
                    serve_cnt_d = serve_inc;
                    if (serve_inc == SERVE_FRAMES) state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (burst_q) begin
                    pend_d = pause_now;
                    if (check_q) begin
                        if (goal_l | goal_r) begin
                            state_d    = S_POINT;
                            scorer_l_d = goal_l;
                            burst_d    = 1'b0;
                            rem_d      = 2'd0;
                            pend_d     = 1'b0;
                        end else if (rem_q != 2'd0) begin
                            step_d = 1'b1;
                            rem_d  = rem_q - 2'd1;
                        end else begin
                            burst_d = 1'b0;
                        end
                    end
                end else if (pause_now) begin
                    state_d = S_PAUSE;
                    pend_d  = 1'b0;
                end else if (bus.frame_start) begin
                    burst_d = 1'b1;
                    step_d  = 1'b1;
                    rem_d   = bus.speed;
                end
            end
            S_PAUSE: begin
                if (pause_edge) state_d = S_PLAY;
            end
            S_POINT: begin
                serve_cnt_d = 8'd0;
                if (scorer_l_q) begin
                    score_l_d = next_l;
                    state_d   = (next_l == MAX_SCORE) ? S_OVER : S_SERVE;
                end else begin
                    score_r_d = next_r;
                    state_d   = (next_r == MAX_SCORE) ? S_OVER : S_SERVE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The ball stays released through POINT and drops into reset as SERVE begins.
        rst_n_d = (state_d == S_PLAY) || (state_d == S_PAUSE) || (state_d == S_POINT);
        over_d  = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            serve_cnt_q <= 8'd0;
            burst_q     <= 1'b0;
            check_q     <= 1'b0;
            rem_q       <= 2'd0;
            pend_q      <= 1'b0;
            scorer_l_q  <= 1'b0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            step_q      <= 1'b0;
            rst_n_q     <= 1'b0;
            over_q      <= 1'b0;
            row_q       <= 13'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start_btn;
            pause_q     <= bus.pause_btn;
            serve_cnt_q <= serve_cnt_d;
            burst_q     <= burst_d;
            check_q     <= check_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            scorer_l_q  <= scorer_l_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            step_q      <= step_d;
            rst_n_q     <= rst_n_d;
            over_q      <= over_d;
            row_q       <= bus.ball_row;
        end
    end

    assign bus.ball_step  = step_q;
    assign bus.ball_rst_n = rst_n_q;
    assign bus.state      = state_q;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
    assign bus.game_over  = over_q;
    assign bus.dbg_row    = row_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: hand-derived vector table, directed corner sequences and
// random stimulus, all compared against a cycle-indexed behavioural model of the game rules.
module tb_pong_game_ctrl;

    localparam int SF = 3;
    localparam int MS = 7;
    localparam int LG = 6;
    localparam int RG = 610;

    logic clk = 1'b0;
    logic reset;
    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .MAX_SCORE   (4'(MS)),
        .SERVE_FRAMES(8'(SF)),
        .LEFT_GOAL   (13'(LG)),
        .RIGHT_GOAL  (13'(RG))
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int step_cnt = 0;
    longint cnum = 0;

    // Behavioural model: a burst is remembered only as its frame cycle and its length;
    // pulses and goal checks are derived from the cycle offset.
    int     m_st, m_sl, m_sr, m_frames, m_N;
    longint m_F;
    bit     m_pend, m_scl, p_st, p_pa;
    bit     m_step, m_rstn, m_over;
    logic [12:0] m_row;

    task automatic model_step(input bit rs, input bit fs, input bit st, input bit pa,
                              input logic [1:0] sp, input logic [12:0] col, input logic [12:0] row);
        bit se, pe, active, stp;
        longint k;
        int nst;
        if (rs) begin
            m_st = 0; m_sl = 0; m_sr = 0; m_frames = 0; m_N = 0; m_F = -100;
            m_pend = 0; m_scl = 0; p_st = 0; p_pa = 0;
            m_step = 0; m_rstn = 0; m_over = 0; m_row = '0;
            return;
        end
        se = st && !p_st;
        pe = pa && !p_pa;
        k = cnum - m_F;
        active = (m_st == 2) && (k > 0) && (k <= 2 * m_N);
        nst = m_st;
        stp = 0;
        case (m_st)
            0, 5: if (se) begin m_sl = 0; m_sr = 0; m_frames = 0; nst = 1; end
            1: if (fs) begin
                m_frames++;
                if (m_frames == SF) nst = 2;
            end
            2: begin
                if (active) begin
                    if (pe) m_pend = 1;
                    if (k % 2 == 0) begin
                        if (int'(col) <= LG || int'(col) >= RG) begin
                            nst = 4; m_scl = (int'(col) >= RG); m_N = 0; m_pend = 0;
                        end else if (k < 2 * m_N) begin
                            stp = 1;
                        end
                    end
                end else if (m_pend || pe) begin
                    nst = 3; m_pend = 0;
                end else if (fs) begin
                    m_F = cnum; m_N = int'(sp) + 1; stp = 1;
                end
            end
            3: if (pe) nst = 2;
            4: begin
                m_frames = 0;
                if (m_scl) begin m_sl++; nst = (m_sl == MS) ? 5 : 1; end
                else       begin m_sr++; nst = (m_sr == MS) ? 5 : 1; end
            end
            default: nst = 0;
        endcase
        p_st = st;
        p_pa = pa;
        m_step = stp;
        m_rstn = (nst == 2) || (nst == 3) || (nst == 4);
        m_over = (nst == 5);
        m_row = row;
        m_st = nst;
    endtask

    function automatic logic [26:0] dut_pack();
        return {bus.state, bus.ball_step, bus.ball_rst_n, bus.score_l, bus.score_r,
                bus.game_over, bus.dbg_row};
    endfunction

    task automatic cyc(input bit rs, input bit fs, input bit st, input bit pa,
                       input logic [1:0] sp, input logic [12:0] col, input logic [12:0] row);
        logic [26:0] got, exp;
        reset = rs;
        bus.frame_start = fs;
        bus.start_btn = st;
        bus.pause_btn = pa;
        bus.speed = sp;
        bus.ball_col = col;
        bus.ball_row = row;
        model_step(rs, fs, st, pa, sp, col, row);
        @(posedge clk);
        #1;
        got = dut_pack();
        exp = {3'(m_st), m_step, m_rstn, 4'(m_sl), 4'(m_sr), m_over, m_row};
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL model cycle %0d: got %h want %h", cnum, got, exp);
        end
        step_cnt += int'(bus.ball_step);
        cnum++;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_mis++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic serve_to_play();
        for (int i = 0; i < 12; i++) begin
            if (m_st == 2) break;
            cyc(0, 1, 0, 0, 2'd0, 13'd300, 13'd1);
        end
        check("serve_to_play state", int'(bus.state), 2);
    endtask

    task automatic play_point(input bit left);
        serve_to_play();
        cyc(0, 1, 0, 0, 2'd0, 13'd300, 13'd2);
        cyc(0, 0, 0, 0, 2'd0, 13'd300, 13'd2);
        cyc(0, 0, 0, 0, 2'd0, left ? 13'd610 : 13'd5, 13'd2);
        check("point state", int'(bus.state), 4);
        cyc(0, 0, 0, 0, 2'd0, 13'd300, 13'd2);
    endtask

    typedef struct {
        bit rs, fs, st, pa;
        logic [1:0]  sp;
        logic [12:0] col;
        logic [2:0]  e_state;
        bit          e_step, e_rstn;
        logic [3:0]  e_sl, e_sr;
        bit          e_over;
    } vec_t;

    function automatic vec_t mk(bit rs, bit fs, bit st, bit pa, logic [1:0] sp, logic [12:0] col,
                                logic [2:0] es, bit estep, bit erstn,
                                logic [3:0] esl, logic [3:0] esr, bit eover);
        vec_t v;
        v.rs = rs; v.fs = fs; v.st = st; v.pa = pa; v.sp = sp; v.col = col;
        v.e_state = es; v.e_step = estep; v.e_rstn = erstn;
        v.e_sl = esl; v.e_sr = esr; v.e_over = eover;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        logic [26:0] want;
        bit st_l, pa_l;
        logic [12:0] col;

        //            rs fs st pa sp  col    | st step rstn sl sr over
        tbl[0]  = mk(1, 0, 0, 0, 0, 300,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 300,  0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 300,  1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 300,  1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 300,  1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 300,  1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 300,  1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0, 0, 300,  2, 0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 3, 300,  2, 0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 3, 300,  2, 1, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 3, 300,  2, 0, 1, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 3, 300,  2, 1, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 3, 300,  2, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 3, 300,  2, 1, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 3, 300,  2, 0, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 3, 300,  2, 1, 1, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 3, 300,  2, 0, 1, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 3, 300,  2, 0, 1, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 3, 300,  2, 0, 1, 0, 0, 0);
        tbl[19] = mk(0, 1, 0, 0, 3, 300,  2, 1, 1, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 3, 300,  2, 0, 1, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 3, 300,  2, 1, 1, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 3, 610,  2, 0, 1, 0, 0, 0);
        tbl[23] = mk(0, 0, 0, 0, 3, 610,  4, 0, 1, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 0, 3, 300,  1, 0, 0, 1, 0, 0);
        tbl[25] = mk(0, 0, 0, 0, 3, 300,  1, 0, 0, 1, 0, 0);

        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].rs, tbl[i].fs, tbl[i].st, tbl[i].pa, tbl[i].sp, tbl[i].col, 13'(i * 7));
            want = {tbl[i].e_state, tbl[i].e_step, tbl[i].e_rstn, tbl[i].e_sl, tbl[i].e_sr,
                    tbl[i].e_over, tbl[i].rs ? 13'd0 : 13'(i * 7)};
            check($sformatf("table row %0d", i), int'(dut_pack()), int'(want));
        end

        // Pause requested mid-burst waits for the burst to finish.
        serve_to_play();
        step_cnt = 0;
        cyc(0, 1, 0, 0, 2'd1, 13'd300, 13'd3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 2'd1, 13'd300, 13'd3);
        check("pause deferred state", int'(bus.state), 2);
        cyc(0, 0, 0, 1, 2'd1, 13'd300, 13'd3);
        check("pause taken state", int'(bus.state), 3);
        check("pre-pause burst steps", step_cnt, 2);
        step_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 2'd3, 13'd300, 13'd3);
            cyc(0, 0, 0, 1, 2'd3, 13'd300, 13'd3);
        end
        check("paused steps", step_cnt, 0);
        cyc(0, 0, 0, 0, 2'd1, 13'd300, 13'd3);
        cyc(0, 0, 0, 1, 2'd1, 13'd300, 13'd3);
        check("unpause state", int'(bus.state), 2);
        step_cnt = 0;
        cyc(0, 1, 0, 1, 2'd1, 13'd300, 13'd3);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 2'd1, 13'd300, 13'd3);
        check("resumed burst steps", step_cnt, 2);
        cyc(0, 0, 0, 0, 2'd1, 13'd300, 13'd3);

        // Goal and pause edge in the same check cycle.
        cyc(0, 1, 0, 0, 2'd0, 13'd300, 13'd4);
        cyc(0, 0, 0, 0, 2'd0, 13'd300, 13'd4);
        cyc(0, 0, 0, 1, 2'd0, 13'd5, 13'd4);
        check("goal+pause point", int'(bus.state), 4);
        cyc(0, 0, 0, 1, 2'd0, 13'd300, 13'd4);
        check("goal+pause serve", int'(bus.state), 1);
        check("goal+pause rst_n", int'(bus.ball_rst_n), 0);
        check("goal+pause score_r", int'(bus.score_r), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 2'd0, 13'd300, 13'd4);
            check("goal+pause no pause", int'(bus.state), 1);
        end

        // Right player runs to MAX_SCORE.
        for (int it = 0; it < 10 && m_sr < MS - 1; it++) play_point(1'b0);
        check("score_r before final", int'(bus.score_r), MS - 1);
        play_point(1'b0);
        check("final score_r", int'(bus.score_r), MS);
        check("final state", int'(bus.state), 5);
        check("final game_over", int'(bus.game_over), 1);
        cyc(0, 0, 0, 0, 2'd0, 13'd300, 13'd5);
        cyc(0, 0, 1, 0, 2'd0, 13'd300, 13'd5);
        check("restart state", int'(bus.state), 1);
        check("restart score_l", int'(bus.score_l), 0);
        check("restart score_r", int'(bus.score_r), 0);
        check("restart game_over", int'(bus.game_over), 0);
        cyc(0, 0, 0, 0, 2'd0, 13'd300, 13'd5);

        // Random play against the model.
        st_l = 0;
        pa_l = 0;
        cyc(1, 0, 0, 0, 2'd0, 13'd300, 13'd0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) st_l = ~st_l;
            if ($urandom_range(0, 11) == 0) pa_l = ~pa_l;
            case ($urandom_range(0, 39))
                0: col = 13'd0;
                1: col = 13'd5;
                2: col = 13'd6;
                3: col = 13'd7;
                4: col = 13'd609;
                5: col = 13'd610;
                6: col = 13'd611;
                7: col = 13'd8191;
                default: col = 13'($urandom_range(100, 500));
            endcase
            cyc($urandom_range(0, 799) == 0, $urandom_range(0, 5) == 0, st_l, pa_l,
                2'($urandom_range(0, 3)), col, 13'($urandom_range(0, 8191)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
